// File: rtl/step_timer.sv
// Periodic step generator: counts qualified ticks of a slow time base and raises a
// held step request every `period` ticks, tracking issued and missed steps.
module step_timer #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned PERIOD_RST = 50,
    parameter int unsigned EDGE_MODE  = 0
) (
    input  logic             mclk,
    input  logic             clr,
    input  logic             tick_in,
    input  logic             start,
    input  logic             stop,
    input  logic             period_load,
    input  logic [WIDTH-1:0] period_in,
    input  logic             step_ack,
    output logic             step_req,
    output logic             running,
    output logic [3:0]       overrun_cnt,
    output logic [15:0]      step_cnt
);

    typedef enum logic [1:0] {StIdle, StRun, StWaitAck} state_e;

    localparam logic [WIDTH-1:0] PeriodTrunc = WIDTH'(PERIOD_RST);
    localparam logic [WIDTH-1:0] PeriodInit  = (PeriodTrunc == '0) ? WIDTH'(1) : PeriodTrunc;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             step_req_q, step_req_d;
    logic             running_q, running_d;
    logic [3:0]       overrun_q, overrun_d;
    logic [15:0]      step_cnt_q, step_cnt_d;
    logic             tick_prev_q;

    logic             tick_qual;
    logic [WIDTH:0]   cnt_inc;
    logic             period_done;

    // In edge mode only the rising edge of the divided square wave counts.
    assign tick_qual   = (EDGE_MODE != 0) ? (tick_in & ~tick_prev_q) : tick_in;
    assign cnt_inc     = {1'b0, cnt_q} + (WIDTH+1)'(1);
    assign period_done = tick_qual && (cnt_inc >= {1'b0, period_q});

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        period_d   = period_q;
        step_req_d = step_req_q;
        overrun_d  = overrun_q;
        step_cnt_d = step_cnt_q;

        if (period_load) begin
            period_d = (period_in == '0) ? WIDTH'(1) : period_in;
        end

        if (stop) begin
            state_d    = StIdle;
            step_req_d = 1'b0;
            cnt_d      = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    cnt_d = '0;
                    if (start) begin
                        state_d   = StRun;
                        overrun_d = '0;
                    end
                end
                StRun: begin
                    if (tick_qual) begin
                        cnt_d = period_done ? '0 : cnt_inc[WIDTH-1:0];
                    end
                    if (period_done) begin
                        step_req_d = 1'b1;
                        step_cnt_d = step_cnt_q + 16'd1;
                        state_d    = StWaitAck;
                    end
                end
                StWaitAck: begin
                    if (tick_qual) begin
                        cnt_d = period_done ? '0 : cnt_inc[WIDTH-1:0];
                    end
                    // A completion while unacknowledged is lost, never queued.
                    if (period_done) begin
                        if (step_ack) begin
                            step_cnt_d = step_cnt_q + 16'd1;
                        end else if (overrun_q != 4'hF) begin
                            overrun_d = overrun_q + 4'd1;
                        end
                    end else if (step_ack) begin
                        step_req_d = 1'b0;
                        state_d    = StRun;
                    end
                end
                default: begin
                    state_d    = StIdle;
                    step_req_d = 1'b0;
                    cnt_d      = '0;
                end
            endcase
        end

        running_d = (state_d != StIdle);
    end

    always_ff @(posedge mclk) begin
        if (clr) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            period_q    <= PeriodInit;
            step_req_q  <= 1'b0;
            running_q   <= 1'b0;
            overrun_q   <= '0;
            step_cnt_q  <= '0;
            tick_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            period_q    <= period_d;
            step_req_q  <= step_req_d;
            running_q   <= running_d;
            overrun_q   <= overrun_d;
            step_cnt_q  <= step_cnt_d;
            tick_prev_q <= tick_in;
        end
    end

    assign step_req    = step_req_q;
    assign running     = running_q;
    assign overrun_cnt = overrun_q;
    assign step_cnt    = step_cnt_q;

endmodule

// File: tb/tb_step_timer.sv
// Directed bench for step_timer: a strobe-mode instance and an edge-mode instance
// share control inputs but have separate tick inputs.
module tb_step_timer;

    logic        mclk = 1'b0;
    logic        clr = 1'b1;
    logic        tick0 = 1'b0;
    logic        tick1 = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        period_load = 1'b0;
    logic [7:0]  period_in = 8'd0;
    logic        step_ack = 1'b0;

    logic        req0, run0, req1, run1;
    logic [3:0]  ovr0, ovr1;
    logic [15:0] scnt0, scnt1;

    int checks = 0;
    int errors = 0;

    step_timer #(.WIDTH(8), .PERIOD_RST(50), .EDGE_MODE(0)) dut0 (
        .mclk(mclk), .clr(clr), .tick_in(tick0), .start(start), .stop(stop),
        .period_load(period_load), .period_in(period_in), .step_ack(step_ack),
        .step_req(req0), .running(run0), .overrun_cnt(ovr0), .step_cnt(scnt0)
    );

    step_timer #(.WIDTH(8), .PERIOD_RST(50), .EDGE_MODE(1)) dut1 (
        .mclk(mclk), .clr(clr), .tick_in(tick1), .start(start), .stop(stop),
        .period_load(period_load), .period_in(period_in), .step_ack(step_ack),
        .step_req(req1), .running(run1), .overrun_cnt(ovr1), .step_cnt(scnt1)
    );

    always #5 mclk = ~mclk;

    task automatic cyc();
        @(posedge mclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic strobe0(input logic ack);
        tick0 = 1'b1;
        step_ack = ack;
        cyc();
        tick0 = 1'b0;
        step_ack = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
    endtask

    task automatic load(input logic [7:0] p);
        period_in = p;
        period_load = 1'b1;
        cyc();
        period_load = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
    endtask

    initial begin
        cyc();
        cyc();
        clr = 1'b0;
        chk("rst_req", 32'(req0), 32'd0);
        chk("rst_run", 32'(run0), 32'd0);
        chk("rst_ovr", 32'(ovr0), 32'd0);
        chk("rst_scnt", 32'(scnt0), 32'd0);

        // Period 3, strobes: request 1 cycle after the third strobe.
        load(8'd3);
        pulse_start();
        chk("start_run", 32'(run0), 32'd1);
        strobe0(1'b0);
        chk("p3_s1_req", 32'(req0), 32'd0);
        cyc();
        strobe0(1'b0);
        chk("p3_s2_req", 32'(req0), 32'd0);
        strobe0(1'b0);
        chk("p3_s3_req", 32'(req0), 32'd1);
        chk("p3_s3_scnt", 32'(scnt0), 32'd1);
        step_ack = 1'b1;
        cyc();
        step_ack = 1'b0;
        chk("ack_req", 32'(req0), 32'd0);
        chk("ack_run", 32'(run0), 32'd1);

        // Period 2, no ack over 6 strobes.
        do_clr();
        load(8'd2);
        pulse_start();
        for (int i = 0; i < 6; i++) strobe0(1'b0);
        chk("ovr_req", 32'(req0), 32'd1);
        chk("ovr_cnt", 32'(ovr0), 32'd2);
        chk("ovr_scnt", 32'(scnt0), 32'd1);

        // Ack coinciding with a completion issues a fresh step.
        pulse_stop();
        pulse_start();
        chk("restart_ovr", 32'(ovr0), 32'd0);
        chk("restart_scnt", 32'(scnt0), 32'd1);
        strobe0(1'b0);
        strobe0(1'b0);
        chk("same_pre_scnt", 32'(scnt0), 32'd2);
        strobe0(1'b0);
        strobe0(1'b1);
        chk("same_req", 32'(req0), 32'd1);
        chk("same_scnt", 32'(scnt0), 32'd3);
        chk("same_ovr", 32'(ovr0), 32'd0);

        // Stop in WAIT_ACK, then start+stop together in IDLE.
        pulse_stop();
        chk("stop_req", 32'(req0), 32'd0);
        chk("stop_run", 32'(run0), 32'd0);
        chk("stop_scnt", 32'(scnt0), 32'd3);
        start = 1'b1;
        stop = 1'b1;
        cyc();
        start = 1'b0;
        stop = 1'b0;
        chk("startstop_run", 32'(run0), 32'd0);
        for (int i = 0; i < 4; i++) strobe0(1'b0);
        chk("idle_tick_req", 32'(req0), 32'd0);
        chk("idle_tick_scnt", 32'(scnt0), 32'd3);

        // Stray ack in RUN is ignored; then saturate overrun with period 1.
        pulse_start();
        step_ack = 1'b1;
        cyc();
        step_ack = 1'b0;
        chk("stray_ack_req", 32'(req0), 32'd0);
        chk("stray_ack_scnt", 32'(scnt0), 32'd3);
        load(8'd0);
        strobe0(1'b0);
        chk("p1_req", 32'(req0), 32'd1);
        chk("p1_scnt", 32'(scnt0), 32'd4);
        for (int i = 0; i < 16; i++) strobe0(1'b0);
        chk("sat_ovr", 32'(ovr0), 32'd15);
        chk("sat_scnt", 32'(scnt0), 32'd4);

        // clr in WAIT_ACK with overrun 3; then reset period of 50.
        do_clr();
        load(8'd0);
        pulse_start();
        for (int i = 0; i < 4; i++) strobe0(1'b0);
        chk("pre_clr_ovr", 32'(ovr0), 32'd3);
        chk("pre_clr_scnt", 32'(scnt0), 32'd1);
        do_clr();
        chk("clr_req", 32'(req0), 32'd0);
        chk("clr_run", 32'(run0), 32'd0);
        chk("clr_ovr", 32'(ovr0), 32'd0);
        chk("clr_scnt", 32'(scnt0), 32'd0);
        pulse_start();
        for (int i = 0; i < 49; i++) strobe0(1'b0);
        chk("p50_49_req", 32'(req0), 32'd0);
        strobe0(1'b0);
        chk("p50_50_req", 32'(req0), 32'd1);
        chk("p50_scnt", 32'(scnt0), 32'd1);

        // Edge mode: square wave period 8 cycles, period 2.
        do_clr();
        load(8'd2);
        pulse_start();
        for (int k = 0; k < 40; k++) begin
            tick1 = ((k % 8) < 4);
            cyc();
            if (k == 7) chk("edge_k7_req", 32'(req1), 32'd0);
            if (k == 8) chk("edge_k8_req", 32'(req1), 32'd1);
        end
        chk("edge_scnt", 32'(scnt1), 32'd1);
        chk("edge_ovr", 32'(ovr1), 32'd1);
        tick1 = 1'b1;
        for (int k = 0; k < 20; k++) cyc();
        chk("held_ovr", 32'(ovr1), 32'd2);
        step_ack = 1'b1;
        cyc();
        step_ack = 1'b0;
        chk("edge_ack_req", 32'(req1), 32'd0);
        chk("edge_ack_run", 32'(run1), 32'd1);
        tick1 = 1'b0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
